// File: rtl/flowstate_csr_master.sv
// CSR command initiator for the flowstate table mod port: read/write/clear/clear-range to single-beat requests.
// Optional read-response timeout enabled by defining FLOWSTATE_CSR_TIMEOUT_EN.
module flowstate_csr_master #(
  parameter int FLOWSTATE_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int OPCODE_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 cmd_op,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr_end,
  input  logic [FLOWSTATE_WIDTH-1:0] cmd_wdata,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic [FLOWSTATE_WIDTH-1:0] rsp_data,
  output logic                       rsp_err,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ADDR_WIDTH-1:0]      m_mod_addr,
  output logic [FLOWSTATE_WIDTH-1:0] m_mod_data,
  output logic [OPCODE_WIDTH-1:0]    m_mod_opcode,
  output logic                       m_mod_valid,
  input  logic                       m_mod_ready,
  input  logic [FLOWSTATE_WIDTH-1:0] s_mod_bdata,
  input  logic                       s_mod_bvalid,
  output logic                       s_mod_bready
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [OPCODE_WIDTH-1:0] OPC_RD = OPCODE_WIDTH'(4'b1100);
  localparam logic [OPCODE_WIDTH-1:0] OPC_WR = OPCODE_WIDTH'(4'b1101);
  localparam logic [OPCODE_WIDTH-1:0] OPC_CL = OPCODE_WIDTH'(4'b1110);
  localparam logic [1:0] CMD_RD = 2'b00;
  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [1:0] CMD_CR = 2'b11;

  if (FLOWSTATE_WIDTH < ADDR_WIDTH + 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("flowstate_csr_master: FLOWSTATE_WIDTH must be >= ADDR_WIDTH+1 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RSP} state_t;

  state_t                     state, state_next;
  logic [1:0]                 op_q, op_next;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_next;
  logic [ADDR_WIDTH-1:0]      end_q, end_next;
  logic [FLOWSTATE_WIDTH-1:0] data_q, data_next;
  logic [OPCODE_WIDTH-1:0]    opc_q, opc_next;
  logic [CNT_W-1:0]           cnt_q, cnt_next;
  logic [FLOWSTATE_WIDTH-1:0] rdata_q, rdata_next;
  logic                       err_q, err_next;
`ifdef FLOWSTATE_CSR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0]           tmo_q, tmo_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      end_q   <= '0;
      data_q  <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef FLOWSTATE_CSR_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state   <= state_next;
      op_q    <= op_next;
      addr_q  <= addr_next;
      end_q   <= end_next;
      data_q  <= data_next;
      opc_q   <= opc_next;
      cnt_q   <= cnt_next;
      rdata_q <= rdata_next;
      err_q   <= err_next;
`ifdef FLOWSTATE_CSR_TIMEOUT_EN
      tmo_q   <= tmo_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    op_next    = op_q;
    addr_next  = addr_q;
    end_next   = end_q;
    data_next  = data_q;
    opc_next   = opc_q;
    cnt_next   = cnt_q;
    rdata_next = rdata_q;
    err_next   = err_q;
`ifdef FLOWSTATE_CSR_TIMEOUT_EN
    tmo_next   = tmo_q;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_next   = cmd_op;
          addr_next = cmd_addr;
          end_next  = cmd_addr_end;
          cnt_next  = '0;
          data_next = (cmd_op == CMD_WR) ? cmd_wdata : '0;
          case (cmd_op)
            CMD_RD:  opc_next = OPC_RD;
            CMD_WR:  opc_next = OPC_WR;
            default: opc_next = OPC_CL;
          endcase
          // An inverted range is rejected without touching the table.
          if (cmd_op == CMD_CR && cmd_addr_end < cmd_addr) begin
            state_next = RSP;
            rdata_next = '0;
            err_next   = 1'b1;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (m_mod_ready) begin
          case (op_q)
            CMD_RD: begin
              state_next = WAIT_RD;
`ifdef FLOWSTATE_CSR_TIMEOUT_EN
              tmo_next   = '0;
`endif
            end
            CMD_CR: begin
              cnt_next = cnt_q + 1'b1;
              // Compare before incrementing so a range ending at the top address never wraps.
              if (addr_q == end_q) begin
                state_next = RSP;
                rdata_next = FLOWSTATE_WIDTH'(cnt_q + 1'b1);
                err_next   = 1'b0;
              end else begin
                addr_next = addr_q + 1'b1;
              end
            end
            default: begin
              state_next = RSP;
              rdata_next = '0;
              err_next   = 1'b0;
            end
          endcase
        end
      end
      WAIT_RD: begin
        if (s_mod_bvalid) begin
          state_next = RSP;
          rdata_next = s_mod_bdata;
          err_next   = 1'b0;
        end
`ifdef FLOWSTATE_CSR_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = RSP;
          rdata_next = '0;
          err_next   = 1'b1;
        end else begin
          tmo_next = tmo_q + 1'b1;
        end
`endif
      end
      RSP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready    = (state == IDLE) && !rst;
  assign m_mod_valid  = (state == ISSUE);
  assign m_mod_addr   = addr_q;
  assign m_mod_data   = data_q;
  assign m_mod_opcode = opc_q;
  assign s_mod_bready = (state == IDLE) || (state == WAIT_RD);
  assign rsp_valid    = (state == RSP);
  assign rsp_data     = rdata_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_flowstate_csr_master.sv
// Scoreboard bench for flowstate_csr_master: expected beats/responses queued at stimulus time, popped by monitors.
module tb_flowstate_csr_master;

  localparam int FW = 32;
  localparam int AW = 10;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_addr_end = '0;
  logic [FW-1:0] cmd_wdata = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [FW-1:0] rsp_data;
  logic          rsp_err;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [AW-1:0] m_mod_addr;
  logic [FW-1:0] m_mod_data;
  logic [OW-1:0] m_mod_opcode;
  logic          m_mod_valid;
  logic          m_mod_ready = 1'b1;
  logic [FW-1:0] s_mod_bdata = '0;
  logic          s_mod_bvalid = 1'b0;
  logic          s_mod_bready;

  flowstate_csr_master #(
    .FLOWSTATE_WIDTH(FW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_addr_end(cmd_addr_end), .cmd_wdata(cmd_wdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .m_mod_addr(m_mod_addr), .m_mod_data(m_mod_data), .m_mod_opcode(m_mod_opcode),
    .m_mod_valid(m_mod_valid), .m_mod_ready(m_mod_ready),
    .s_mod_bdata(s_mod_bdata), .s_mod_bvalid(s_mod_bvalid), .s_mod_bready(s_mod_bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [FW-1:0] data;
    logic [OW-1:0] op;
  } beat_t;
  typedef struct {
    logic [FW-1:0] data;
    logic          err;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  logic [FW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Beat/response monitors and held-request stability while stalled.
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [FW-1:0] prev_data;
  logic [OW-1:0] prev_op;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && m_mod_valid) begin
        check_eq("stall_addr", 64'(m_mod_addr), 64'(prev_addr));
        check_eq("stall_data", 64'(m_mod_data), 64'(prev_data));
        check_eq("stall_op", 64'(m_mod_opcode), 64'(prev_op));
      end
      if (m_mod_valid && m_mod_ready) begin
        if (beat_q.size() == 0) begin
          check_eq("beat_unexpected", 64'(beat_q.size()), 64'(1));
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check_eq("beat_addr", 64'(m_mod_addr), 64'(b.addr));
          check_eq("beat_data", 64'(m_mod_data), 64'(b.data));
          check_eq("beat_op", 64'(m_mod_opcode), 64'(b.op));
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check_eq("rsp_unexpected", 64'(rsp_q.size()), 64'(1));
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check_eq("rsp_data", 64'(rsp_data), 64'(r.data));
          check_eq("rsp_err", 64'(rsp_err), 64'(r.err));
        end
      end
      prev_stall <= m_mod_valid && !m_mod_ready;
    end else begin
      prev_stall <= 1'b0;
    end
    prev_addr <= m_mod_addr;
    prev_data <= m_mod_data;
    prev_op   <= m_mod_opcode;
  end

  task automatic push_beat(input logic [AW-1:0] a, input logic [FW-1:0] d, input logic [OW-1:0] o);
    beat_t b;
    b.addr = a; b.data = d; b.op = o;
    beat_q.push_back(b);
  endtask

  task automatic push_rsp(input logic [FW-1:0] d, input logic e);
    rsp_t r;
    r.data = d; r.err = e;
    rsp_q.push_back(r);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [AW-1:0] aend, input logic [FW-1:0] wdata, output bit ok);
    ok = 1'b0;
    cmd_op = op; cmd_addr = addr; cmd_addr_end = aend; cmd_wdata = wdata; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("cmd_accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW-1:0] aend,
                        input logic [FW-1:0] wdata, input logic [3:0] pat, input int pat_len,
                        input bit give_bv, input int hold, input int exp_lat);
    logic [FW-1:0] rd_val;
    logic [FW-1:0] held;
    bit ok, bv_go;
    int n, k;
    rd_val = mem[addr];
    case (op)
      2'b00: begin
        push_beat(addr, '0, 4'b1100);
        if (give_bv) push_rsp(rd_val, 1'b0); else push_rsp('0, 1'b1);
      end
      2'b01: begin push_beat(addr, wdata, 4'b1101); push_rsp('0, 1'b0); mem[addr] = wdata; end
      2'b10: begin push_beat(addr, '0, 4'b1110); push_rsp('0, 1'b0); mem[addr] = '0; end
      default: begin
        if (aend < addr) begin
          push_rsp('0, 1'b1);
        end else begin
          for (int a = int'(addr); a <= int'(aend); a++) begin
            push_beat(AW'(a), '0, 4'b1110);
            mem[a] = '0;
          end
          push_rsp(FW'(int'(aend) - int'(addr) + 1), 1'b0);
        end
      end
    endcase
    rsp_ready = (hold == 0);
    send_cmd(op, addr, aend, wdata, ok);
    if (!ok) return;
    m_mod_ready = pat[0];
    k = 0; n = 0; bv_go = 1'b0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
      if (give_bv && m_mod_valid && m_mod_ready && m_mod_opcode == 4'b1100) bv_go = 1'b1;
      @(posedge clk); #1;
      s_mod_bvalid = bv_go;
      s_mod_bdata  = bv_go ? rd_val : '0;
      bv_go = 1'b0;
      k++;
      m_mod_ready = (k < pat_len) ? pat[k] : 1'b1;
    end
    m_mod_ready = 1'b1;
    if (!rsp_valid) check_eq("rsp_wait_timeout", 64'(0), 64'(1));
    if (exp_lat >= 0) check_eq("latency", 64'(n), 64'(exp_lat));
    if (hold > 0) begin
      held = rsp_data;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("hold_valid", 64'(rsp_valid), 64'(1));
        check_eq("hold_data", 64'(rsp_data), 64'(held));
        check_eq("hold_cmd_ready", 64'(cmd_ready), 64'(0));
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < (1 << AW); i++) mem[i] = FW'(i * 32'h01010101);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_rsp_err", 64'(rsp_err), 64'(0));
    check_eq("rst_rsp_data", 64'(rsp_data), 64'(0));
    check_eq("rst_m_valid", 64'(m_mod_valid), 64'(0));
    check_eq("rst_m_addr", 64'(m_mod_addr), 64'(0));
    check_eq("rst_m_data", 64'(m_mod_data), 64'(0));
    check_eq("rst_m_opcode", 64'(m_mod_opcode), 64'(0));
    check_eq("rst_bready", 64'(s_mod_bready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    do_cmd(2'b01, 10'h005, 10'h000, 32'hDEADBEEF, 4'b0001, 1, 1'b0, 0, 2);
    do_cmd(2'b00, 10'h005, 10'h000, 32'h0, 4'b0001, 1, 1'b1, 0, 3);
    do_cmd(2'b01, 10'h3FF, 10'h000, 32'h12345678, 4'b0001, 1, 1'b0, 0, 2);
    do_cmd(2'b11, 10'h3FD, 10'h3FF, 32'hFFFFFFFF, 4'b1101, 4, 1'b0, 0, 5);
    do_cmd(2'b00, 10'h3FF, 10'h000, 32'h0, 4'b0001, 1, 1'b1, 0, 3);
    do_cmd(2'b11, 10'h010, 10'h00F, 32'h0, 4'b0001, 1, 1'b0, 0, 1);
    do_cmd(2'b01, 10'h2A0, 10'h000, 32'hCAFEF00D, 4'b0001, 1, 1'b0, 0, 2);
    do_cmd(2'b00, 10'h2A0, 10'h000, 32'h0, 4'b0001, 1, 1'b1, 5, 3);
    do_cmd(2'b10, 10'h2A0, 10'h000, 32'h0, 4'b0001, 1, 1'b0, 0, 2);
    do_cmd(2'b00, 10'h2A0, 10'h000, 32'h0, 4'b0001, 1, 1'b1, 0, 3);
    do_cmd(2'b11, 10'h020, 10'h020, 32'h0, 4'b0001, 1, 1'b0, 0, 2);

`ifdef FLOWSTATE_CSR_TIMEOUT_EN
    do_cmd(2'b00, 10'h005, 10'h000, 32'h0, 4'b0001, 1, 1'b0, 0, 10);
`endif

    // Stray read-back data while idle must be dropped.
    s_mod_bvalid = 1'b1; s_mod_bdata = 32'h55555555;
    @(posedge clk); #1;
    s_mod_bvalid = 1'b0; s_mod_bdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stray_rsp_valid", 64'(rsp_valid), 64'(0));
    end
    check_eq("stray_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    // Reset in the middle of a clear-range: two beats complete, then abandon.
    m_mod_ready = 1'b1;
    push_beat(10'h100, '0, 4'b1110);
    push_beat(10'h101, '0, 4'b1110);
    send_cmd(2'b11, 10'h100, 10'h1FF, 32'h0, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_mid_m_valid", 64'(m_mod_valid), 64'(0));
    check_eq("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_eq("post_rst_m_valid", 64'(m_mod_valid), 64'(0));
    end
    check_eq("rst_beats_left", 64'(beat_q.size()), 64'(0));
    beat_q.delete();
    @(posedge clk); #1;

    do_cmd(2'b00, 10'h005, 10'h000, 32'h0, 4'b0001, 1, 1'b1, 0, 3);

    repeat (3) @(negedge clk);
    check_eq("beat_q_empty", 64'(beat_q.size()), 64'(0));
    check_eq("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
